// File: rtl/thermo_filter.sv
// Samples the MAX6675 word periodically, accepts it once stable, and
// keeps a moving average with a hysteretic over-temperature alarm.
module thermo_filter #(
  parameter int SAMPLE_DIV    = 5000000,
  parameter int AVG_LOG2      = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 64,
  parameter int ALARM_HI      = 400,
  parameter int ALARM_HYST    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] temperature,
  output logic [15:0] temp_avg,
  output logic        temp_valid,
  output logic        alarm,
  output logic        sample_drop
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 12 + AVG_LOG2;
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int OW = $clog2(TIMEOUT + 1);
  localparam logic [11:0] HI = 12'(ALARM_HI);
  localparam logic [11:0] LO = 12'(ALARM_HI - ALARM_HYST);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    PRIME,
    ACCUM,
    OUTPUT
  } state_t;

  state_t state, state_nxt;

  logic [11:0]         s1, s2, smp;
  logic [TW-1:0]       timer;
  logic [CW-1:0]       stab_cnt, stab_nxt;
  logic [OW-1:0]       to_cnt, to_nxt;
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [SW-1:0]       sum;
  logic [11:0]         avg;
  logic [11:0]         mem [N];
  logic                primed, tick, same;
  logic                accept, timeout;
  logic                unused_hi;

  assign unused_hi = ^temperature[15:12];
  assign avg       = sum[SW-1:AVG_LOG2];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    timeout   = 1'b0;
    tick      = (timer == '0);
    same      = (s1 == s2);
    stab_nxt  = same ? stab_cnt + 1'b1 : '0;
    to_nxt    = to_cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (tick) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // stability wins if both limits land on the same clock
        if (stab_nxt == CW'(STABLE_CYCLES)) begin
          accept    = 1'b1;
          state_nxt = primed ? ACCUM : PRIME;
        end else if (to_nxt == OW'(TIMEOUT)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      PRIME: begin
        if (&wr_ptr) state_nxt = OUTPUT;
      end
      ACCUM:   state_nxt = OUTPUT;
      OUTPUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      timer       <= TW'(SAMPLE_DIV - 1);
      stab_cnt    <= '0;
      to_cnt      <= '0;
      smp         <= '0;
      wr_ptr      <= '0;
      primed      <= 1'b0;
      sum         <= '0;
      temp_avg    <= '0;
      temp_valid  <= 1'b0;
      alarm       <= 1'b0;
      sample_drop <= 1'b0;
    end else begin
      s1          <= temperature[11:0];
      s2          <= s1;
      timer       <= tick ? TW'(SAMPLE_DIV - 1) : timer - 1'b1;
      temp_valid  <= 1'b0;
      sample_drop <= timeout;
      if (state == IDLE) begin
        stab_cnt <= '0;
        to_cnt   <= '0;
      end
      if (state == CAPTURE) begin
        stab_cnt <= stab_nxt;
        to_cnt   <= to_nxt;
      end
      if (accept) smp <= s2;
      if (state == PRIME) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (&wr_ptr) begin
          sum    <= SW'(smp) << AVG_LOG2;
          primed <= 1'b1;
        end
      end
      if (state == ACCUM) begin
        // modular full-width arithmetic; the final sum always fits
        sum    <= sum - SW'(mem[wr_ptr]) + SW'(smp);
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (state == OUTPUT) begin
        temp_avg   <= {4'b0, avg};
        temp_valid <= 1'b1;
        if (avg >= HI)     alarm <= 1'b1;
        else if (avg < LO) alarm <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state == PRIME || state == ACCUM))
      mem[wr_ptr] <= smp;
  end

endmodule

// File: tb/tb_thermo_filter.sv
// Directed and random checks of thermo_filter against a
// moving-window average model with hysteretic alarm.
module tb_thermo_filter;

  localparam int SAMPLE_DIV    = 100;
  localparam int AVG_LOG2      = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int TIMEOUT       = 16;
  localparam int ALARM_HI      = 400;
  localparam int ALARM_HYST    = 20;
  localparam int N             = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] temperature = '0;
  logic [15:0] temp_avg;
  logic        temp_valid;
  logic        alarm;
  logic        sample_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;

  int  win[$];
  bit  mprimed;
  bit  malarm;
  int  mavg;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  thermo_filter #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .AVG_LOG2(AVG_LOG2),
    .STABLE_CYCLES(STABLE_CYCLES),
    .TIMEOUT(TIMEOUT),
    .ALARM_HI(ALARM_HI),
    .ALARM_HYST(ALARM_HYST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .temperature(temperature),
    .temp_avg(temp_avg),
    .temp_valid(temp_valid),
    .alarm(alarm),
    .sample_drop(sample_drop)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    win.delete();
    mprimed = 1'b0;
    malarm  = 1'b0;
    mavg    = 0;
  endfunction

  function automatic void model_accept(input int v);
    int s;
    if (!mprimed) begin
      win.delete();
      for (int i = 0; i < N; i++) win.push_back(v);
      mprimed = 1'b1;
    end else begin
      void'(win.pop_front());
      win.push_back(v);
    end
    s = 0;
    foreach (win[i]) s += win[i];
    mavg = s / N;
    if (mavg >= ALARM_HI) malarm = 1'b1;
    else if (mavg < ALARM_HI - ALARM_HYST) malarm = 1'b0;
  endfunction

  task automatic do_reset(input logic [15:0] v);
    @(negedge clk);
    rst = 1'b1;
    temperature = v;
    repeat (2) @(negedge clk);
    check("rst_avg", 32'(temp_avg), 0);
    check("rst_valid", 32'(temp_valid), 0);
    check("rst_alarm", 32'(alarm), 0);
    check("rst_drop", 32'(sample_drop), 0);
    model_reset();
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic run_period(input string tag,
                            input logic [15:0] v,
                            input bit tog,
                            input int exp_avg,
                            input int exp_alarm,
                            output int ev);
    int n;
    bit got;
    temperature = v;
    got = 1'b0;
    n = 0;
    ev = -1;
    while (!got && n < 3 * SAMPLE_DIV) begin
      @(negedge clk);
      n++;
      if (temp_valid || sample_drop) got = 1'b1;
      else if (tog) temperature = temperature ^ 16'h0001;
    end
    check({tag, "_event"}, 32'(got), 1);
    if (got) begin
      ev = cyc;
      if (tog) begin
        check({tag, "_drop"}, 32'(sample_drop), 1);
        check({tag, "_novalid"}, 32'(temp_valid), 0);
      end else begin
        model_accept(int'(v[11:0]));
        check({tag, "_valid"}, 32'(temp_valid), 1);
        check({tag, "_nodrop"}, 32'(sample_drop), 0);
      end
      check({tag, "_avg_model"}, 32'(temp_avg), 32'(mavg));
      check({tag, "_alarm_model"}, 32'(alarm), 32'(malarm));
      if (exp_avg >= 0)
        check({tag, "_avg"}, 32'(temp_avg), 32'(exp_avg));
      if (exp_alarm >= 0)
        check({tag, "_alarm"}, 32'(alarm), 32'(exp_alarm));
      @(negedge clk);
      check({tag, "_valid_pulse"}, 32'(temp_valid), 0);
      check({tag, "_drop_pulse"}, 32'(sample_drop), 0);
    end
  endtask

  initial begin
    int e1, e2, e3, lat;
    bit tog;
    logic [15:0] v;

    // constant 100 degC: prime then steady repeats
    do_reset(16'h0190);
    run_period("t1a", 16'h0190, 1'b0, 400, 1, e1);
    lat = e1 - rel_cyc;
    run_period("t1b", 16'h0190, 1'b0, 400, 1, e2);
    run_period("t1c", 16'h0190, 1'b0, 400, 1, e3);
    check("t1_prime_vs_accum", 32'(e2 - e1), 32'(SAMPLE_DIV - (N - 1)));
    check("t1_period", 32'(e3 - e2), 32'(SAMPLE_DIV));

    // upper nibble ignored, then step response
    do_reset(16'hF064);
    run_period("t5", 16'hF064, 1'b0, 100, 0, e1);
    run_period("t2a", 16'd200, 1'b0, 125, 0, e1);
    run_period("t2b", 16'd200, 1'b0, 150, 0, e2);
    run_period("t2c", 16'd200, 1'b0, 175, 0, e1);
    run_period("t2d", 16'd200, 1'b0, 200, 0, e1);
    check("t2_period", 32'(e2 >= 0 ? e1 - e2 : -1), 32'(2 * SAMPLE_DIV));

    // hysteresis band
    do_reset(16'd400);
    run_period("t3a", 16'd400, 1'b0, 400, 1, e1);
    run_period("t3b", 16'd340, 1'b0, 385, 1, e1);
    run_period("t3c", 16'd376, 1'b0, 379, 0, e1);
    run_period("t3d", 16'd444, 1'b0, 390, 0, e1);

    // unstable input times out
    run_period("t4a", 16'h0123, 1'b1, 390, 0, e1);
    run_period("t4b", 16'h0456, 1'b1, 390, 0, e2);
    check("t4_period", 32'(e2 - e1), 32'(SAMPLE_DIV));
    run_period("t4c", 16'd444, 1'b0, 401, 1, e1);

    // reset while priming
    do_reset(16'd500);
    while (cyc < rel_cyc + lat - 3) @(negedge clk);
    check("t6_pre_valid", 32'(temp_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_avg0", 32'(temp_avg), 0);
    check("t6_valid0", 32'(temp_valid), 0);
    check("t6_alarm0", 32'(alarm), 0);
    check("t6_drop0", 32'(sample_drop), 0);
    do_reset(16'd300);
    run_period("t6a", 16'd300, 1'b0, 300, 0, e1);
    run_period("t6b", 16'd300, 1'b0, 300, 0, e1);
    run_period("t6c", 16'd200, 1'b0, 275, 0, e1);

    // random values and dropouts
    for (int i = 0; i < 40; i++) begin
      tog = ($urandom_range(0, 4) == 0);
      v[15:12] = 4'($urandom);
      if ($urandom_range(0, 1) == 1) v[11:0] = 12'($urandom_range(340, 460));
      else                           v[11:0] = 12'($urandom);
      run_period("rnd", v, tog, -1, -1, e1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
